cp0_unit: RTL
=============

Name: cp0_unit

Overview:
- Coprocessor-0 for the 5-stage MIPS pipeline; sits at the M stage.
- Consumes the exception-tracking fields (PC, BD flag, ExcCode) that the pipeline registers carry down from D/E, plus six hardware interrupt lines.
- Decides whether to take an exception or interrupt, and records the architectural state (SR, Cause, EPC).
- Serves mfc0/mtc0/eret.
- Drives the global flush and redirect to the handler.

Parameters:
- PRID, 32'h0019_1116, constant value returned for PRId (reg 15).
- HANDLER_PC, 32'h0000_4180, exception/interrupt entry address driven on HandlerPC.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- A1  in  5  mfc0 read register number.
- A2  in  5  mtc0 write register number.
- DIn  in  32  mtc0 write data.
- WE  in  1  mtc0 write enable (M stage).
- PCM  in  32  PC of the instruction in M.
- BDM  in  1  M instruction sits in a branch delay slot.
- ExcCodeM  in  5  [6:2] exception code of the M instruction; 0 = none.
- EretM  in  1  eret in M.
- HWInt  in  6  [7:2] hardware interrupt lines, level-sensitive.
- IntReq  out  1  take exception/interrupt this cycle; flushes F/D/E/M regs.
- HandlerPC  out  32  always HANDLER_PC.
- EPCOut  out  32  current EPC, used as eret target.
- DOut  out  32  mfc0 read data, combinational from A1.

Behaviour:
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
  - EPC (14): 32 bits.
  - PRId (15): read-only, returns PRID.
- Reset (async, immediate): SR=0, Cause=0, EPC=0. IntReq=0 follows combinationally.
- Request logic, combinational, same cycle as inputs:
  - IntPend = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
  - ExcPend = (ExcCodeM != 0) & ~SR.EXL.
  - IntReq = IntPend | ExcPend.
  - Interrupt has priority over exception.
- On a rising edge with IntReq=1:
  - SR.EXL <= 1.
  - Cause.BD <= BDM.
  - Cause.ExcCode <= IntPend ? 0 : ExcCodeM.
  - EPC <= BDM ? {PCM[31:2],2'b00} - 4 : {PCM[31:2],2'b00}.
  - Any mtc0 that cycle is suppressed; the M instruction is being cancelled.
- Cause.IP <= HWInt on every edge, independent of EXL/IE.
- mtc0, when WE=1 and IntReq=0:
  - A2=12 writes SR (masked fields only).
  - A2=14 writes EPC (DIn[31:2],2'b00).
  - A2=13, A2=15 and all other numbers are ignored.
- eret (EretM=1, IntReq=0): SR.EXL <= 0 on the edge. EPCOut is valid the same cycle for redirect.
- Precedence on one edge: Reset > IntReq capture > eret > mtc0.
  - eret together with mtc0 SR: the write applies first, then EXL is cleared.
- Nested events while EXL=1 are masked. No request is raised, and EPC/Cause.ExcCode/BD hold.
- Latency:
  - DOut and IntReq are combinational (0 cycles).
  - State updates are visible one edge later.
  - mfc0 after mtc0 to the same register in the next cycle reads the new value. No internal bypass; the pipeline already orders these.
- Reads with A1 outside {12,13,14,15} return 0.

Decomposition:
- Shared package `cp0_defs`:
  - register numbers (SR=12, CAUSE=13, EPC=14, PRID=15);
  - field bit positions;
  - ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12).
- The E/M pipeline registers use the same ExcCode constants.
- One sub-module, `cp0_req_logic`: purely combinational IntPend/ExcPend/IntReq and next-Cause.ExcCode computation.
- Register file and sequencing stay in `cp0_unit`.

Test Plan:
- Reset mid-run with SR=32'h0000_FC01: assert Reset between edges → SR, Cause, EPC read 0 immediately; IntReq=0.
- mtc0 SR=32'h0000_0401, then HWInt=6'b000001, PCM=32'h0000_3010, BDM=0 → IntReq=1 same cycle. After the edge: EPC=32'h0000_3010, Cause.ExcCode=0, Cause.IP=6'b000001, SR.EXL=1, IntReq=0.
- ExcCodeM=5'd12 (Ov), PCM=32'h0000_3024, BDM=1, IE=0 → IntReq=1. After the edge: EPC=32'h0000_3020, Cause.BD=1, ExcCode=12.
- ExcCodeM=4 and IntPend both set → interrupt wins: ExcCode=0. A simultaneous mtc0 EPC=32'h1234_5678 is dropped.
- With EXL=1, ExcCodeM=10 and HWInt asserted → IntReq=0; EPC unchanged. eret clears EXL; the pending interrupt is then raised in the next cycle.
- mfc0 A1=15 → DOut=32'h0019_1116. A1=7 → 0. mtc0 A2=13 DIn=32'hFFFF_FFFF → Cause unchanged.

Source files
------------

// File: rtl/cp0_defs.sv
// rtl/cp0_defs.sv - shared CP0 register numbers, field positions and ExcCode values
package cp0_defs;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int SR_IM_HI     = 15;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD     = 31;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // A delay-slot fault restarts at the branch so the branch is re-executed.
    function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic bd);
        logic [31:0] pc_aligned;
        pc_aligned = pc & 32'hFFFF_FFFC;
        return bd ? (pc_aligned - 32'd4) : pc_aligned;
    endfunction

endpackage

// File: rtl/cp0_req_logic.sv
// rtl/cp0_req_logic.sv - combinational interrupt/exception request decision
module cp0_req_logic
    import cp0_defs::*;
(
    input  logic [5:0] hwint_i,
    input  logic [5:0] im_i,
    input  logic       ie_i,
    input  logic       exl_i,
    input  logic [4:0] exccode_m_i,
    output logic       int_pend_o,
    output logic       exc_pend_o,
    output logic       int_req_o,
    output logic [4:0] exccode_next_o
);

    always_comb begin
        int_pend_o     = (|(hwint_i & im_i)) & ie_i & ~exl_i;
        exc_pend_o     = (exccode_m_i != EXC_INT) & ~exl_i;
        int_req_o      = int_pend_o | exc_pend_o;
        exccode_next_o = int_pend_o ? EXC_INT : exccode_m_i;
    end

endmodule

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - MIPS coprocessor 0: SR/Cause/EPC/PRId, exception capture, mfc0/mtc0/eret
module cp0_unit
    import cp0_defs::*;
#(
    parameter logic [31:0] PRID       = 32'h0019_1116,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PCM,
    input  logic        BDM,
    input  logic [4:0]  ExcCodeM,
    input  logic        EretM,
    input  logic [5:0]  HWInt,
    output logic        IntReq,
    output logic [31:0] HandlerPC,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;

    logic        int_pend;
    logic        exc_pend;
    logic [4:0]  exc_next;

    cp0_req_logic u_req (
        .hwint_i        (HWInt),
        .im_i           (im_q),
        .ie_i           (ie_q),
        .exl_i          (exl_q),
        .exccode_m_i    (ExcCodeM),
        .int_pend_o     (int_pend),
        .exc_pend_o     (exc_pend),
        .int_req_o      (IntReq),
        .exccode_next_o (exc_next)
    );

    // Capture cancels the M instruction, so its mtc0/eret must not land.
    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        ip_d  = HWInt;
        exc_d = exc_q;
        epc_d = epc_q;
        if (IntReq) begin
            exl_d = 1'b1;
            bd_d  = BDM;
            exc_d = exc_next;
            epc_d = epc_target(PCM, BDM);
        end else begin
            if (WE) begin
                case (A2)
                    REG_SR: begin
                        im_d  = DIn[SR_IM_HI:SR_IM_LO];
                        exl_d = DIn[SR_EXL];
                        ie_d  = DIn[SR_IE];
                    end
                    REG_EPC: epc_d = DIn & 32'hFFFF_FFFC;
                    default: ;
                endcase
            end
            if (EretM) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    always_comb begin
        DOut = '0;
        case (A1)
            REG_SR: begin
                DOut[SR_IM_HI:SR_IM_LO] = im_q;
                DOut[SR_EXL]            = exl_q;
                DOut[SR_IE]             = ie_q;
            end
            REG_CAUSE: begin
                DOut[CAUSE_BD]                  = bd_q;
                DOut[CAUSE_IP_HI:CAUSE_IP_LO]   = ip_q;
                DOut[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_q;
            end
            REG_EPC:  DOut = epc_q;
            REG_PRID: DOut = PRID;
            default:  DOut = '0;
        endcase
    end

    assign HandlerPC = HANDLER_PC;
    assign EPCOut    = epc_q;

endmodule
